// File: rtl/ram_arbiter.sv
// Two-port arbiter and _OE/_WE strobe sequencer for the shared async SRAM; owns the D tri-state.
// Latency: req sampled at edge 0, ack pulses in cycle 2+ACC_CYCLES; back-to-back transactions take 3+ACC_CYCLES cycles.
// Backpressure: req is held until ack; losers stay pending. RAM_ARBITER_ROUND_ROBIN_EN selects round-robin over fixed priority.
module ram_arbiter #(
    parameter int AWIDTH     = 16,
    parameter int DWIDTH     = 8,
    parameter int ACC_CYCLES = 2
) (
    input  logic              clk,
    input  logic              _MR,
    input  logic              req0,
    input  logic              we0,
    input  logic [AWIDTH-1:0] addr0,
    input  logic [DWIDTH-1:0] wdata0,
    output logic              ack0,
    output logic [DWIDTH-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [AWIDTH-1:0] addr1,
    input  logic [DWIDTH-1:0] wdata1,
    output logic              ack1,
    output logic [DWIDTH-1:0] rdata1,
    output logic              _OE,
    output logic              _WE,
    output logic [AWIDTH-1:0] A,
    inout  wire  [DWIDTH-1:0] D
);

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    localparam logic ROUND_ROBIN = 1'b1;
`else
    localparam logic ROUND_ROBIN = 1'b0;
`endif

    localparam int CW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              lat_we;
    logic              lat_port;
    logic              last_grant;
    logic              d_drv;
    logic [DWIDTH-1:0] d_out;
    logic              pick1;

    // Port 1 wins only when alone, or on a tie when round-robin says it is its turn.
    assign pick1 = req1 & (~req0 | (ROUND_ROBIN & ~last_grant));

    assign D = d_drv ? d_out : {DWIDTH{1'bz}};

    always_ff @(posedge clk or negedge _MR) begin
        if (!_MR) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_port   <= 1'b0;
            last_grant <= 1'b1;
            d_drv      <= 1'b0;
            d_out      <= '0;
            _OE        <= 1'b1;
            _WE        <= 1'b1;
            A          <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        lat_port <= pick1;
                        lat_we   <= pick1 ? we1 : we0;
                        A        <= pick1 ? addr1 : addr0;
                        d_out    <= pick1 ? wdata1 : wdata0;
                        // Reads open _OE in SETUP; writes only drive D there.
                        d_drv    <= pick1 ? we1 : we0;
                        _OE      <= pick1 ? we1 : we0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    cnt   <= CW'(ACC_CYCLES - 1);
                    _WE   <= ~lat_we;
                    state <= ACCESS;
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        _WE        <= 1'b1;
                        _OE        <= 1'b1;
                        last_grant <= lat_port;
                        if (lat_port) begin
                            ack1 <= 1'b1;
                            if (!lat_we) rdata1 <= D;
                        end else begin
                            ack0 <= 1'b1;
                            if (!lat_we) rdata0 <= D;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    // Write data is held through DONE, released before the turnaround IDLE.
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    d_drv <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
`timescale 1ns/1ps
module tb_ram_arbiter;
    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int ACC = 2;
    localparam logic [DW-1:0] UNDEF  = 8'h5A;
    localparam logic [DW-1:0] SETTLE = 8'hEE;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          _MR = 1'b1;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, _OE, _WE;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] A;
    wire  [DW-1:0] D;

    always #20 clk = ~clk;

    ram_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .ACC_CYCLES(ACC)) dut (
        .clk(clk), ._MR(_MR),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        ._OE(_OE), ._WE(_WE), .A(A), .D(D)
    );

    // Behavioural SRAM: data valid 55 ns after the last address/_OE change.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] a_q = '0;
    logic          oe_q = 1'b1;
    int            age = 0;
    always #1 begin
        if (A !== a_q || _OE !== oe_q) begin
            a_q = A; oe_q = _OE; age = 0;
        end else if (age < 1000) begin
            age = age + 1;
        end
    end
    assign D = (!_OE && _WE) ? ((age >= 55) ? mem[a_q] : SETTLE) : {DW{1'bz}};
    always @(posedge _WE) if (_MR) mem[A] = D;

    typedef struct {
        bit            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] exp_mem [logic [AW-1:0]];
    logic [DW-1:0] rd_model [2];
    bit            tb_last = 1'b1;
    int            n_checks = 0, n_errors = 0, overlap = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_exp(input logic [AW-1:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : UNDEF;
    endfunction

    task automatic push(input bit p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.port = p; e.we = w; e.addr = a;
        e.data = w ? d : mem_exp(a);
        if (w) exp_mem[a] = d;
        sb.push_back(e);
    endtask

    task automatic drive(input bit p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    endtask

    task automatic reset_models();
        sb.delete();
        rd_model[0] = '0;
        rd_model[1] = '0;
        tb_last = 1'b1;
    endtask

    // Scoreboard: every ack pops the oldest expected transaction.
    always @(negedge clk) begin
        exp_t e;
        if (_MR && !_OE && !_WE) overlap++;
        if (_MR && (ack0 || ack1)) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'({ack1, ack0}), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_port", 32'({ack1, ack0}), e.port ? 32'd2 : 32'd1);
                if (!e.we) rd_model[e.port] = e.data;
                chk($sformatf("rdata0_after_ack_a%0h", e.addr), 32'(rdata0), 32'(rd_model[0]));
                chk($sformatf("rdata1_after_ack_a%0h", e.addr), 32'(rdata1), 32'(rd_model[1]));
                tb_last = e.port;
            end
        end
    end

    // One isolated transaction with per-cycle strobe, address and bus checks.
    task automatic xact(input bit p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit move_addr);
        logic exp_oe, exp_we;
        @(posedge clk); #1;
        drive(p, w, a, d);
        push(p, w, a, d);
        for (int k = 1; k <= ACC + 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_oe = (k == ACC + 2) ? 1'b1 : w;
            exp_we = (k >= 2 && k <= ACC + 1) ? !w : 1'b1;
            chk($sformatf("oe_a%0h_k%0d", a, k), 32'(_OE), 32'(exp_oe));
            chk($sformatf("we_a%0h_k%0d", a, k), 32'(_WE), 32'(exp_we));
            chk($sformatf("addr_a%0h_k%0d", a, k), 32'(A), 32'(a));
            if (w) chk($sformatf("dbus_a%0h_k%0d", a, k), 32'(D), 32'(d));
            chk($sformatf("ack_time_a%0h_k%0d", a, k), 32'(p ? ack1 : ack0), 32'(k == ACC + 2));
            if (move_addr && k == 2) begin
                if (p) addr1 = 16'h00FF; else addr0 = 16'h00FF;
            end
        end
        @(posedge clk); #1;
        if (p) req1 = 1'b0; else req0 = 1'b0;
        @(negedge clk);
        chk($sformatf("ack_pulse_a%0h", a), 32'(p ? ack1 : ack0), 32'd0);
        chk($sformatf("oe_turnaround_a%0h", a), 32'(_OE), 32'd1);
    endtask

    task automatic held_both();
        logic [AW-1:0] ha [2];
        logic [DW-1:0] hd [2];
        bit win;
        int acks;
        ha[0] = 16'h0010; ha[1] = 16'h0020;
        hd[0] = 8'hA0;    hd[1] = 8'hB1;
        win = tb_last;
        for (int i = 0; i < 4; i++) begin
            win = RR ? !win : 1'b0;
            push(win, 1'b1, ha[win], hd[win]);
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b1, ha[0], hd[0]);
        drive(1'b1, 1'b1, ha[1], hd[1]);
        acks = 0;
        for (int c = 0; c < 60 && acks < 4; c++) begin
            @(negedge clk);
            if (ack0 || ack1) acks++;
        end
        chk("held_ack_count", 32'(acks), 32'd4);
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = UNDEF;
        reset_models();

        #5 _MR = 1'b0;
        #1;
        chk("rst_oe", 32'(_OE), 32'd1);
        chk("rst_we", 32'(_WE), 32'd1);
        chk("rst_addr", 32'(A), 32'd0);
        chk("rst_acks", 32'({ack1, ack0}), 32'd0);
        chk("rst_rdata", 32'({rdata1, rdata0}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) _MR = 1'b1;

        // Reset asserted mid-write while _WE is low.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 16'h0100, 8'h77);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midwr_we_low", 32'(_WE), 32'd0);
        #5 _MR = 1'b0;
        #1;
        chk("midwr_rst_we", 32'(_WE), 32'd1);
        chk("midwr_rst_oe", 32'(_OE), 32'd1);
        chk("midwr_rst_acks", 32'({ack1, ack0}), 32'd0);
        chk("midwr_rst_addr", 32'(A), 32'd0);
        req0 = 1'b0;
        reset_models();
        repeat (2) @(posedge clk);
        @(negedge clk) _MR = 1'b1;

        held_both();

        xact(1'b0, 1'b1, 16'h0001, 8'h01, 1'b0);
        xact(1'b0, 1'b0, 16'h0001, 8'h00, 1'b0);
        xact(1'b1, 1'b1, 16'h0002, 8'h02, 1'b0);
        xact(1'b0, 1'b0, 16'h0002, 8'h00, 1'b0);
        xact(1'b0, 1'b1, 16'h0003, 8'h33, 1'b1);
        xact(1'b0, 1'b0, 16'h0003, 8'h00, 1'b0);
        xact(1'b0, 1'b0, 16'h00FF, 8'h00, 1'b0);
        xact(1'b1, 1'b0, 16'h1234, 8'h00, 1'b0);
        xact(1'b1, 1'b0, 16'h0020, 8'h00, 1'b0);
        xact(1'b0, 1'b0, 16'h0010, 8'h00, 1'b0);

        repeat (3) @(negedge clk);
        chk("strobe_overlap", 32'(overlap), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
